// File: rtl/cpu6_mainfsm.sv
// cpu6_mainfsm -- multi-cycle main control FSM for the cpu6 core.
//
// Walks each instruction through fetch, decode, execute, memory and
// writeback. It steers the ALU operand muxes and the result mux, and
// produces the aluop field for the ALU decoder. It also owns the single
// shared memory port through a req/ack handshake.
//
// Ports:
//   clk        core clock
//   reset      asynchronous active-high reset, forces FETCH immediately
//   opcode     instr[6:0] from the instruction register (used in DECODE/MEMADR)
//   mem_ack    memory completes the current access this cycle
//   mem_req    memory access request, held until mem_ack
//   memwrite   current request is a write
//   adrsrc     memory address select: 0=PC, 1=ALU result register
//   irwrite    load the instruction register
//   pcupdate   unconditional PC load
//   branch     PC load qualified by the datapath zero flag
//   regwrite   register file write enable
//   alusrca    operand A select: 00=PC, 01=oldPC, 10=rs1
//   alusrcb    operand B select: 00=rs2, 01=imm, 10=constant 4
//   resultsrc  result select: 00=ALU result reg, 01=memory data, 10=ALU output
//   aluop      00=add, 01=subtract (compare), 10=funct-decoded
//   illegal_op one-cycle pulse on an unsupported opcode
//   instr_done one-cycle pulse on the final cycle of each instruction
//   dbg_state  current state
module cpu6_mainfsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               memwrite,
  output logic               adrsrc,
  output logic               irwrite,
  output logic               pcupdate,
  output logic               branch,
  output logic               regwrite,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         resultsrc,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10),
    ILLEGAL  = STATE_W'(11)
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t state;

  // State register. Memory states hold until mem_ack; every other state
  // lasts one cycle. Unused encodings fall back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ack) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECUTER;
            OP_ITYPE:          state <= EXECUTEI;
            OP_JAL:            state <= JAL;
            OP_BEQ:            state <= BEQ;
            default:           state <= ILLEGAL;
          endcase
        end
        // opcode[5] separates store (0100011) from load (0000011)
        MEMADR:   state <= opcode[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ack) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ack) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        JAL:      state <= ALUWB;
        BEQ:      state <= FETCH;
        ILLEGAL:  state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  assign dbg_state = state;

  // Output decode. Everything is forced low while reset is held, so the
  // memory port never sees a request even though the state reads FETCH.
  // The fetch-side loads and the store completion pulse wait for mem_ack.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    aluop      = 2'b00;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alusrcb   = 2'b10;
          resultsrc = 2'b10;
          irwrite   = mem_ack;
          pcupdate  = mem_ack;
        end
        DECODE: begin
          alusrca = 2'b01;
          alusrcb = 2'b01;
        end
        MEMADR: begin
          alusrca = 2'b10;
          alusrcb = 2'b01;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adrsrc  = 1'b1;
        end
        MEMWB: begin
          resultsrc  = 2'b01;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          mem_req    = 1'b1;
          memwrite   = 1'b1;
          adrsrc     = 1'b1;
          instr_done = mem_ack;
        end
        EXECUTER: begin
          alusrca = 2'b10;
          aluop   = 2'b10;
        end
        EXECUTEI: begin
          alusrca = 2'b10;
          alusrcb = 2'b01;
          aluop   = 2'b10;
        end
        ALUWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        JAL: begin
          alusrca  = 2'b01;
          alusrcb  = 2'b10;
          pcupdate = 1'b1;
        end
        BEQ: begin
          alusrca    = 2'b10;
          aluop      = 2'b01;
          branch     = 1'b1;
          instr_done = 1'b1;
        end
        ILLEGAL: begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_mainfsm.sv
// tb_cpu6_mainfsm -- self-checking bench for cpu6_mainfsm.
//
// Each instruction is planned as a list of steps built from its class and
// chosen wait counts. Every step's expected outputs come from the state
// table, and a single compare process checks them each cycle. Instruction
// latency is checked separately against the cycle-count formula, and a few
// directed runs pin literal latencies and pulse counts.
module tb_cpu6_mainfsm;

  localparam int STATE_W = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3;
  localparam int S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7;
  localparam int S_ALUWB = 8, S_JAL = 9, S_BEQ = 10, S_ILLEGAL = 11;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BEQ = 5, C_ILL = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [6:0]         opcode;
  logic               mem_ack;
  logic               mem_req, memwrite, adrsrc, irwrite, pcupdate, branch, regwrite;
  logic [1:0]         alusrca, alusrcb, resultsrc, aluop;
  logic               illegal_op, instr_done;
  logic [STATE_W-1:0] dbg_state;

  cpu6_mainfsm #(.STATE_W(STATE_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
    .pcupdate(pcupdate), .branch(branch), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc), .aluop(aluop),
    .illegal_op(illegal_op), .instr_done(instr_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic        chk_en = 1'b0;
  logic [20:0] exp_vec = '0;
  wire  [20:0] got_vec = {mem_req, memwrite, adrsrc, irwrite, pcupdate, branch,
                          regwrite, illegal_op, instr_done,
                          alusrca, alusrcb, resultsrc, aluop, dbg_state};

  // One comparison: counts it, and reports the values if they differ.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs of one cycle, straight from the state table.
  function automatic logic [20:0] expOut(input int st, input logic ack);
    logic mr = 0, mw = 0, ad = 0, ir = 0, pc = 0, br = 0, rw = 0, il = 0, dn = 0;
    logic [1:0] a = 0, b = 0, r = 0, op = 0;
    case (st)
      S_FETCH:    begin mr = 1; b = 2'b10; r = 2'b10; ir = ack; pc = ack; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin mr = 1; ad = 1; end
      S_MEMWB:    begin r = 2'b01; rw = 1; dn = 1; end
      S_MEMWRITE: begin mr = 1; mw = 1; ad = 1; dn = ack; end
      S_EXECR:    begin a = 2'b10; op = 2'b10; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
      S_ALUWB:    begin rw = 1; dn = 1; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pc = 1; end
      S_BEQ:      begin a = 2'b10; op = 2'b01; br = 1; dn = 1; end
      S_ILLEGAL:  begin il = 1; dn = 1; end
      default:    begin end
    endcase
    return {mr, mw, ad, ir, pc, br, rw, il, dn, a, b, r, op, STATE_W'(st)};
  endfunction

  function automatic logic [6:0] opcOf(input int cls);
    logic [6:0] o;
    case (cls)
      C_LW:    o = OP_LW;
      C_SW:    o = OP_SW;
      C_R:     o = OP_R;
      C_I:     o = OP_I;
      C_JAL:   o = OP_JAL;
      C_BEQ:   o = OP_BEQ;
      default: begin
        o = 7'($urandom);
        while (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_JAL || o == OP_BEQ)
          o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  // The compare process: every enabled cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) checkOutput("cycle_outputs", 32'(got_vec), 32'(exp_vec));
  end

  // Runs one instruction. wf = fetch wait cycles, wm = load/store wait
  // cycles, tie = hold mem_ack high outside the memory waits.
  task automatic applyStimulus(input int cls, input logic [6:0] opc, input int wf, input int wm,
                               input bit tie, output int done_cyc, output int ill_cyc,
                               output int rw_cnt, output int mw_cnt);
    int   ph[$];
    logic ackq[$];
    int   expect_cyc;
    bit   waitable;
    for (int i = 0; i <= wf; i++) begin ph.push_back(S_FETCH); ackq.push_back(i == wf); end
    ph.push_back(S_DECODE); ackq.push_back(1'b0);
    case (cls)
      C_LW: begin
        ph.push_back(S_MEMADR); ackq.push_back(1'b0);
        for (int i = 0; i <= wm; i++) begin ph.push_back(S_MEMREAD); ackq.push_back(i == wm); end
        ph.push_back(S_MEMWB); ackq.push_back(1'b0);
      end
      C_SW: begin
        ph.push_back(S_MEMADR); ackq.push_back(1'b0);
        for (int i = 0; i <= wm; i++) begin ph.push_back(S_MEMWRITE); ackq.push_back(i == wm); end
      end
      C_R:   begin ph.push_back(S_EXECR); ph.push_back(S_ALUWB); ackq.push_back(1'b0); ackq.push_back(1'b0); end
      C_I:   begin ph.push_back(S_EXECI); ph.push_back(S_ALUWB); ackq.push_back(1'b0); ackq.push_back(1'b0); end
      C_JAL: begin ph.push_back(S_JAL);   ph.push_back(S_ALUWB); ackq.push_back(1'b0); ackq.push_back(1'b0); end
      C_BEQ: begin ph.push_back(S_BEQ);     ackq.push_back(1'b0); end
      default: begin ph.push_back(S_ILLEGAL); ackq.push_back(1'b0); end
    endcase
    done_cyc = 0; ill_cyc = 0; rw_cnt = 0; mw_cnt = 0;
    foreach (ph[k]) begin
      waitable = (ph[k] == S_FETCH || ph[k] == S_MEMREAD || ph[k] == S_MEMWRITE);
      opcode   = (ph[k] == S_DECODE || ph[k] == S_MEMADR) ? opc : 7'($urandom);
      mem_ack  = waitable ? ackq[k] : (tie ? 1'b1 : 1'($urandom_range(0, 1)));
      exp_vec  = expOut(ph[k], mem_ack);
      chk_en   = 1'b1;
      @(negedge clk);
      if (instr_done && done_cyc == 0) done_cyc = k + 1;
      if (illegal_op) ill_cyc = k + 1;
      if (regwrite) rw_cnt++;
      if (memwrite) mw_cnt++;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    // Latency from the per-class cycle counts plus one per wait cycle.
    case (cls)
      C_LW:    expect_cyc = 5 + wf + wm;
      C_SW:    expect_cyc = 4 + wf + wm;
      C_BEQ:   expect_cyc = 3 + wf;
      C_ILL:   expect_cyc = 3 + wf;
      default: expect_cyc = 4 + wf;
    endcase
    checkOutput("instr_latency", 32'(done_cyc), 32'(expect_cyc));
  endtask

  int d, il, rw, mw;

  initial begin
    reset = 1'b1; mem_ack = 1'b0; opcode = 7'd0;
    #2;
    checkOutput("reset_outputs", 32'(got_vec), 32'd0);
    mem_ack = 1'b1;
    #1;
    checkOutput("reset_ignores_ack", 32'(got_vec), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_ack = 1'b0;
    reset   = 1'b0;

    // Directed instructions with hand-computed latencies and pulse counts.
    applyStimulus(C_R, OP_R, 0, 0, 1'b1, d, il, rw, mw);
    checkOutput("rtype_cycles", 32'(d), 32'd4);
    checkOutput("rtype_regwrite", 32'(rw), 32'd1);
    applyStimulus(C_LW, OP_LW, 0, 3, 1'b0, d, il, rw, mw);
    checkOutput("lw_wait3_cycles", 32'(d), 32'd8);
    checkOutput("lw_regwrite", 32'(rw), 32'd1);
    checkOutput("lw_memwrite", 32'(mw), 32'd0);
    applyStimulus(C_SW, OP_SW, 0, 0, 1'b0, d, il, rw, mw);
    checkOutput("sw_cycles", 32'(d), 32'd4);
    checkOutput("sw_regwrite", 32'(rw), 32'd0);
    checkOutput("sw_memwrite", 32'(mw), 32'd1);
    applyStimulus(C_BEQ, OP_BEQ, 0, 0, 1'b0, d, il, rw, mw);
    checkOutput("beq_cycles", 32'(d), 32'd3);
    applyStimulus(C_ILL, 7'b1111111, 0, 0, 1'b0, d, il, rw, mw);
    checkOutput("illegal_cycles", 32'(d), 32'd3);
    checkOutput("illegal_pulse_cycle", 32'(il), 32'd3);
    checkOutput("illegal_regwrite", 32'(rw), 32'd0);
    applyStimulus(C_JAL, OP_JAL, 0, 0, 1'b0, d, il, rw, mw);
    checkOutput("jal_cycles", 32'(d), 32'd4);
    checkOutput("jal_regwrite", 32'(rw), 32'd1);

    // Reset in the middle of a stalled load read.
    opcode = OP_LW; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("memread_stall", 32'({mem_req, adrsrc, memwrite, dbg_state}), 32'({3'b110, 4'd3}));
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_mid_read", 32'(got_vec), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("fetch_after_reset", 32'({mem_req, adrsrc, dbg_state}), 32'({2'b10, 4'd0}));

    // Random instruction mix with random memory latencies.
    for (int n = 0; n < 300; n++) begin
      automatic int cls = $urandom_range(0, 6);
      automatic int wf  = $urandom_range(0, 2);
      automatic int wm  = $urandom_range(0, 3);
      applyStimulus(cls, opcOf(cls), wf, wm, 1'b0, d, il, rw, mw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
